// File: rtl/muxkey_pkg.sv
// Shared types and helpers for the runtime-programmable key lookup table.
package muxkey_pkg;

    typedef enum logic {
        RESP_EMPTY = 1'b0,
        RESP_FULL  = 1'b1
    } resp_state_e;

    // Widest match vector popcount_gt1 accepts; callers zero-extend into it.
    localparam int POP_W = 256;

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic popcount_gt1(input logic [POP_W-1:0] v);
        return |(v & (v - POP_W'(1)));
    endfunction

endpackage

// File: rtl/muxkey_match.sv
// Combinational priority match: lowest valid index whose key equals the request wins.
module muxkey_match
    import muxkey_pkg::*;
#(
    parameter int NR_KEY   = 8,
    parameter int KEY_LEN  = 3,
    parameter int DATA_LEN = 64,
    parameter int IDX_W    = $clog2(NR_KEY)
) (
    input  logic [KEY_LEN-1:0]  key,
    input  logic [NR_KEY-1:0]   valid,
    input  logic [KEY_LEN-1:0]  key_tab  [NR_KEY],
    input  logic [DATA_LEN-1:0] data_tab [NR_KEY],
    input  logic [DATA_LEN-1:0] def,
    output logic [DATA_LEN-1:0] data,
    output logic                hit,
    output logic [IDX_W-1:0]    idx,
    output logic                multi
);

    logic [NR_KEY-1:0] match;

    always_comb begin
        for (int i = 0; i < NR_KEY; i++) begin
            match[i] = valid[i] && (key_tab[i] == key);
        end
    end

    // Walk downwards so the lowest matching index is the last assignment.
    always_comb begin
        data = def;
        hit  = 1'b0;
        idx  = '0;
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (match[i]) begin
                data = data_tab[i];
                hit  = 1'b1;
                idx  = IDX_W'(i);
            end
        end
    end

    assign multi = popcount_gt1(POP_W'(match));

endmodule

// File: rtl/muxkey_lut_reg.sv
// Runtime-programmable key->data table with a single registered, back-pressured response stage.
module muxkey_lut_reg
    import muxkey_pkg::*;
#(
    parameter int NR_KEY   = 8,
    parameter int KEY_LEN  = 3,
    parameter int DATA_LEN = 64,
    parameter int IDX_W    = $clog2(NR_KEY)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                wr_inval,
    input  logic                flush,
    input  logic                def_we,
    input  logic [DATA_LEN-1:0] def_data,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [KEY_LEN-1:0]  req_key,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_LEN-1:0] resp_data,
    output logic                resp_hit,
    output logic [IDX_W-1:0]    resp_idx,
    output logic                resp_multi
);

    logic [NR_KEY-1:0]   valid_q;
    logic [KEY_LEN-1:0]  key_q  [NR_KEY];
    logic [DATA_LEN-1:0] data_q [NR_KEY];
    logic [DATA_LEN-1:0] def_q;

    // Out-of-range wr_idx matches no entry, so such writes fall through harmlessly.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            def_q   <= '0;
            for (int i = 0; i < NR_KEY; i++) begin
                key_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (flush) begin
                valid_q <= '0;
            end
            for (int i = 0; i < NR_KEY; i++) begin
                if (wr_en && (wr_idx == IDX_W'(i))) begin
                    if (wr_inval) begin
                        valid_q[i] <= 1'b0;
                    end else begin
                        valid_q[i] <= 1'b1;
                        key_q[i]   <= wr_key;
                        data_q[i]  <= wr_data;
                    end
                end
            end
            if (def_we) begin
                def_q <= def_data;
            end
        end
    end

    // ---- stage p0: lookup against the pre-update table ----
    logic [DATA_LEN-1:0] data_p0;
    logic                hit_p0;
    logic [IDX_W-1:0]    idx_p0;
    logic                multi_p0;

    muxkey_match #(
        .NR_KEY   (NR_KEY),
        .KEY_LEN  (KEY_LEN),
        .DATA_LEN (DATA_LEN),
        .IDX_W    (IDX_W)
    ) u_match (
        .key      (req_key),
        .valid    (valid_q),
        .key_tab  (key_q),
        .data_tab (data_q),
        .def      (def_q),
        .data     (data_p0),
        .hit      (hit_p0),
        .idx      (idx_p0),
        .multi    (multi_p0)
    );

    // ---- stage p1: registered response ----
    resp_state_e         state_p1;
    logic [DATA_LEN-1:0] data_p1;
    logic                hit_p1;
    logic [IDX_W-1:0]    idx_p1;
    logic                multi_p1;
    logic                accept;

    assign req_ready = (state_p1 == RESP_EMPTY) || resp_ready;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1 <= RESP_EMPTY;
            data_p1  <= '0;
            hit_p1   <= 1'b0;
            idx_p1   <= '0;
            multi_p1 <= 1'b0;
        end else begin
            case (state_p1)
                RESP_EMPTY: begin
                    if (accept) begin
                        state_p1 <= RESP_FULL;
                        data_p1  <= data_p0;
                        hit_p1   <= hit_p0;
                        idx_p1   <= idx_p0;
                        multi_p1 <= multi_p0;
                    end
                end
                RESP_FULL: begin
                    if (accept) begin
                        data_p1  <= data_p0;
                        hit_p1   <= hit_p0;
                        idx_p1   <= idx_p0;
                        multi_p1 <= multi_p0;
                    end else if (resp_ready) begin
                        state_p1 <= RESP_EMPTY;
                    end
                end
                default: state_p1 <= RESP_EMPTY;
            endcase
        end
    end

    assign resp_valid = (state_p1 == RESP_FULL);
    assign resp_data  = data_p1;
    assign resp_hit   = hit_p1;
    assign resp_idx   = idx_p1;
    assign resp_multi = multi_p1;

endmodule

// File: tb/tb_muxkey_lut_reg.sv
// Directed plus randomized bench for muxkey_lut_reg against a table-level reference model.
module tb_muxkey_lut_reg;

    localparam int NR  = 6;
    localparam int KL  = 3;
    localparam int DL  = 64;
    localparam int IW  = $clog2(NR);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [IW-1:0] wr_idx = '0;
    logic [KL-1:0] wr_key = '0;
    logic [DL-1:0] wr_data = '0;
    logic          wr_inval = 1'b0;
    logic          flush = 1'b0;
    logic          def_we = 1'b0;
    logic [DL-1:0] def_data = '0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [KL-1:0] req_key = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [DL-1:0] resp_data;
    logic          resp_hit;
    logic [IW-1:0] resp_idx;
    logic          resp_multi;

    muxkey_lut_reg #(
        .NR_KEY   (NR),
        .KEY_LEN  (KL),
        .DATA_LEN (DL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_key     (wr_key),
        .wr_data    (wr_data),
        .wr_inval   (wr_inval),
        .flush      (flush),
        .def_we     (def_we),
        .def_data   (def_data),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_key    (req_key),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_hit   (resp_hit),
        .resp_idx   (resp_idx),
        .resp_multi (resp_multi)
    );

    always #5 clk = ~clk;

    // Reference model: the table as plain arrays and the response slot as a bag of fields.
    logic          m_vld  [NR];
    logic [KL-1:0] m_key  [NR];
    logic [DL-1:0] m_data [NR];
    logic [DL-1:0] m_def;
    logic          e_vld;
    logic [DL-1:0] e_data;
    logic          e_hit;
    logic [IW-1:0] e_idx;
    logic          e_multi;

    int compared   = 0;
    int mismatched = 0;
    bit armed      = 1'b0;

    task automatic chk(input string tag, input logic [DL-1:0] obs, input logic [DL-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NR; i++) begin
            m_vld[i]  = 1'b0;
            m_key[i]  = '0;
            m_data[i] = '0;
        end
        m_def   = '0;
        e_vld   = 1'b0;
        e_data  = '0;
        e_hit   = 1'b0;
        e_idx   = '0;
        e_multi = 1'b0;
    endtask

    // Collect every matching index; the first one wins, more than one means a duplicate.
    task automatic model_lookup(input logic [KL-1:0] k);
        int hits[$];
        for (int i = 0; i < NR; i++) begin
            if (m_vld[i] && m_key[i] == k) hits.push_back(i);
        end
        e_hit   = (hits.size() > 0);
        e_idx   = e_hit ? IW'(hits[0]) : '0;
        e_data  = e_hit ? m_data[hits[0]] : m_def;
        e_multi = (hits.size() > 1);
    endtask

    task automatic step();
        logic acc;
        #1;
        if (armed) chk("req_ready", {63'd0, req_ready}, {63'd0, (!e_vld || resp_ready)});
        if (rst) begin
            model_clear();
        end else begin
            acc = req_valid && (!e_vld || resp_ready);
            if (acc) begin
                model_lookup(req_key);
                e_vld = 1'b1;
            end else if (resp_ready) begin
                e_vld = 1'b0;
            end
            if (flush) begin
                for (int i = 0; i < NR; i++) m_vld[i] = 1'b0;
            end
            if (wr_en && int'(wr_idx) < NR) begin
                if (wr_inval) begin
                    m_vld[wr_idx] = 1'b0;
                end else begin
                    m_vld[wr_idx]  = 1'b1;
                    m_key[wr_idx]  = wr_key;
                    m_data[wr_idx] = wr_data;
                end
            end
            if (def_we) m_def = def_data;
        end
        @(posedge clk);
        #1;
        armed = 1'b1;
        chk("resp_valid", {63'd0, resp_valid}, {63'd0, e_vld});
        chk("resp_data", resp_data, e_data);
        chk("resp_hit", {63'd0, resp_hit}, {63'd0, e_hit});
        chk("resp_idx", {{(DL-IW){1'b0}}, resp_idx}, {{(DL-IW){1'b0}}, e_idx});
        chk("resp_multi", {63'd0, resp_multi}, {63'd0, e_multi});
    endtask

    task automatic write(input int idx, input logic [KL-1:0] k, input logic [DL-1:0] d, input logic inval);
        wr_en = 1'b1; wr_idx = IW'(idx); wr_key = k; wr_data = d; wr_inval = inval;
        step();
        wr_en = 1'b0; wr_inval = 1'b0;
    endtask

    task automatic lookup(input logic [KL-1:0] k);
        req_valid = 1'b1; req_key = k;
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        model_clear();

        // reset state
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_data", resp_data, 64'd0);

        // basic hit
        write(0, 3'b010, 64'hA5, 1'b0);
        lookup(3'b010);
        chk("hit_data", resp_data, 64'hA5);
        chk("hit_idx", {61'd0, resp_idx}, 64'd0);
        chk("hit_flag", {63'd0, resp_hit}, 64'd1);
        step();

        // miss returns programmed default
        def_we = 1'b1; def_data = 64'hDEAD;
        step();
        def_we = 1'b0;
        lookup(3'b111);
        chk("miss_data", resp_data, 64'hDEAD);
        chk("miss_hit", {63'd0, resp_hit}, 64'd0);

        // duplicates: lowest index wins, multi flagged; invalidate exposes the next
        write(2, 3'b001, 64'h22, 1'b0);
        write(5, 3'b001, 64'h55, 1'b0);
        lookup(3'b001);
        chk("dup_data", resp_data, 64'h22);
        chk("dup_multi", {63'd0, resp_multi}, 64'd1);
        write(2, 3'b000, 64'h0, 1'b1);
        lookup(3'b001);
        chk("inv_data", resp_data, 64'h55);
        chk("inv_idx", {61'd0, resp_idx}, 64'd5);

        // stall with a pending request, then stream keys 0..7
        lookup(3'b010);
        resp_ready = 1'b0; req_valid = 1'b1; req_key = 3'b011;
        for (int c = 0; c < 3; c++) step();
        chk("stall_ready", {63'd0, req_ready}, 64'd0);
        chk("stall_data", resp_data, 64'hA5);
        resp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req_key = KL'(k);
            step();
        end
        req_valid = 1'b0;
        step();

        // read-before-write
        req_valid = 1'b1; req_key = 3'b010;
        wr_en = 1'b1; wr_idx = '0; wr_key = 3'b010; wr_data = 64'h77;
        step();
        wr_en = 1'b0; req_valid = 1'b0;
        chk("rbw_old", resp_data, 64'hA5);
        lookup(3'b010);
        chk("rbw_new", resp_data, 64'h77);

        // flush with a simultaneous write: only the written entry survives
        flush = 1'b1;
        write(1, 3'b100, 64'h44, 1'b0);
        flush = 1'b0;
        lookup(3'b010);
        chk("flush_miss", {63'd0, resp_hit}, 64'd0);
        lookup(3'b100);
        chk("flush_keep", {61'd0, resp_idx}, 64'd1);

        // out-of-range index write is dropped
        write(6, 3'b011, 64'h66, 1'b0);
        write(7, 3'b011, 64'h67, 1'b0);
        lookup(3'b011);
        chk("oor_miss", {63'd0, resp_hit}, 64'd0);

        // reset while FULL and stalled
        resp_ready = 1'b0;
        lookup(3'b100);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_full_valid", {63'd0, resp_valid}, 64'd0);
        resp_ready = 1'b1;
        lookup(3'b100);
        chk("post_rst_data", resp_data, 64'd0);
        chk("post_rst_hit", {63'd0, resp_hit}, 64'd0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst        = ($urandom_range(0, 79) == 0);
            wr_en      = ($urandom_range(0, 2) == 0);
            wr_idx     = IW'($urandom_range(0, 7));
            wr_key     = KL'($urandom);
            wr_data    = {$urandom, $urandom};
            wr_inval   = ($urandom_range(0, 3) == 0);
            flush      = ($urandom_range(0, 39) == 0);
            def_we     = ($urandom_range(0, 7) == 0);
            def_data   = {$urandom, $urandom};
            req_valid  = ($urandom_range(0, 1) == 0);
            req_key    = KL'($urandom);
            resp_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/muxkey_lut_reg.md
Name: muxkey_lut_reg

Overview:
Runtime-programmable key→data lookup table with a registered response stage and valid/ready handshakes. It is the sequential, parametrised successor of the combinational key-select muxes. Entries and the miss-default value are written at run time, not wired as a constant LUT. Used in npc wherever a decode or CSR-style select table must be reprogrammed, or must tolerate a stalled consumer.

Parameters:
NR_KEY, 8, number of table entries (≥2; need not be a power of two)
KEY_LEN, 3, key width in bits
DATA_LEN, 64, data width in bits
IDX_W, $clog2(NR_KEY), entry index width (derived; not to be overridden)

Ports:
clk  in  1  clock
rst  in  1  reset
wr_en  in  1  write one entry this cycle
wr_idx  in  IDX_W  entry index to write
wr_key  in  KEY_LEN  key for the written entry
wr_data  in  DATA_LEN  data for the written entry
wr_inval  in  1  with wr_en: clear the entry's valid bit instead of writing it
flush  in  1  clear the valid bits of all entries
def_we  in  1  load default_out register
def_data  in  DATA_LEN  new default value
req_valid  in  1  lookup request valid
req_ready  out  1  lookup request accepted when both valid and ready are high
req_key  in  KEY_LEN  key to look up
resp_valid  out  1  response valid
resp_ready  in  1  consumer accepts the response
resp_data  out  DATA_LEN  matched data, or the default on a miss
resp_hit  out  1  at least one valid entry matched
resp_idx  out  IDX_W  index of the winning entry (0 on a miss)
resp_multi  out  1  more than one valid entry matched

Behaviour:
- Reset: one clock, synchronous, active-high (rst sampled on the clk rising edge).
- On reset: all entry valid bits, keys and data = 0; default register = 0; resp_valid = 0; resp_data/resp_hit/resp_idx/resp_multi = 0.
- Reset overrides every other input in the same cycle. A pending response is dropped.
- Match rule:
  - entry i matches iff valid[i] && key[i] == req_key.
  - Winner = lowest matching index (priority, not OR-merge).
  - resp_multi = popcount(matches) > 1.
- Miss: resp_hit = 0, resp_idx = 0, resp_data = current default register.
- Response stage has two states, EMPTY (resp_valid = 0) and FULL (resp_valid = 1).
- req_ready = !resp_valid || resp_ready (combinational; single-entry pipeline register with no bubble).
- Transitions:
  - Request accepted → stage loads the lookup result and is FULL next cycle. Latency is exactly 1 cycle.
  - FULL && resp_ready && no new accept → EMPTY.
  - FULL && resp_ready && accept → remains FULL with new contents. Throughput is 1 per cycle.
- While FULL && !resp_ready: all resp_* outputs hold stable and req_ready = 0.
- Read-before-write: a lookup accepted in the same cycle as wr_en, flush or def_we uses the pre-update table and default. The update is visible to lookups accepted from the next cycle on.
- A captured response is never altered by later writes or flush.
- Write precedence within one cycle: flush clears all valid bits first. A simultaneous wr_en (non-inval) then sets its entry valid, so write wins over flush for that index.
- wr_idx ≥ NR_KEY (non-power-of-two depth): the write is ignored and no entry changes.
- wr_inval = 1: the entry's valid bit is cleared; its key and data are left unchanged.
- Duplicate keys are legal. They are reported via resp_multi and resolved by the lowest index.
- The block has no other error state.

Decomposition:
- Shared package muxkey_pkg:
  - typedef resp_state_e {RESP_EMPTY, RESP_FULL};
  - function popcount_gt1 for the multi-hit flag.
- One combinational sub-module muxkey_match, parameterised NR_KEY, KEY_LEN, DATA_LEN:
  - inputs: key, valid vector, key array, data array, default;
  - outputs: data, hit, idx, multi.
- The top level holds the table registers, the default register and the response stage.

Test Plan:
- Reset, then write idx0 key=3'b010 data=64'hA5, then req key=3'b010 with resp_ready=1 → one cycle later resp_valid=1, data=64'hA5, hit=1, idx=0, multi=0.
- def_we def_data=64'hDEAD, then req key=3'b111 (unmapped) → resp_data=64'hDEAD, hit=0, idx=0.
- Program idx2 and idx5 both with key=3'b001 (data 0x22 and 0x55), then lookup → data=0x22, idx=2, multi=1. Then wr_inval idx2 and lookup → data=0x55, idx=5, multi=0.
- Hold resp_ready=0 for 3 cycles with req_valid=1 → req_ready=0 and resp outputs stable. Then drop resp_ready-stall and stream back-to-back keys 0..7 → eight responses on consecutive cycles, in order.
- In one cycle, accept a lookup of key=3'b010 while wr_en overwrites that entry's data with 0x77 → response shows the old 0xA5. The next lookup shows 0x77.
- Assert flush and wr_en idx1 key=3'b100 together → only idx1 is valid afterwards. Assert rst while FULL with resp_ready=0 → resp_valid=0 next cycle and all lookups miss with default 0.
